// File: rtl/bcd_pkg.sv
// Shared types and constant helpers for the sequential binary-to-BCD converter.
// Pure declarations: no latency, no flow control.
// The helpers are elaborated at compile time only.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Largest value representable with n decimal digits, i.e. 10^n - 1.
    function automatic longint unsigned pow10_m1(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    // Fewest decimal digits that can hold every unsigned value of the given width.
    function automatic int min_digits(input int bits);
        longint unsigned max_v;
        int              d;
        max_v = (64'd1 << bits) - 64'd1;
        d     = 12;
        for (int k = 12; k >= 1; k--) begin
            if (pow10_m1(k) >= max_v) begin
                d = k;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its input.
module bcd_digit_adj (
    input  logic [3:0] i_dig,
    output logic [3:0] o_dig
);

    assign o_dig = (i_dig >= 4'd5) ? (i_dig + 4'd3) : i_dig;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary to packed BCD converter, saturating on overflow.
// Latency: BIN_W shift cycles after acceptance; BIN_W+2 cycles per conversion at full rate.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int DEC_W = $clog2(pow10_m1(DIGITS) + 64'd1);
    localparam int CMP_W = (BIN_W > DEC_W) ? BIN_W : DEC_W;
    localparam logic [CMP_W-1:0] MAX_DEC = CMP_W'(pow10_m1(DIGITS));
    // When every operand fits, the comparator folds away and overflow is constant 0.
    localparam bit OVF_EN = (DIGITS < min_digits(BIN_W));
    localparam logic [BCD_W-1:0] SAT_BCD = {DIGITS{4'h9}};

    state_t             r_state;
    state_t             w_next;
    logic [BIN_W-1:0]   r_bin;
    logic [BCD_W-1:0]   r_acc;
    logic [BCD_W-1:0]   w_adj;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               w_ovf;
    logic               w_load;
    logic               w_shift;

    assign w_ovf = OVF_EN ? (CMP_W'(bin_in) > MAX_DEC) : 1'b0;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_dig (r_acc[4*g +: 4]),
            .o_dig (w_adj[4*g +: 4])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_shift   = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        bcd_out   = '0;
        overflow  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load = 1'b1;
                    w_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                overflow  = r_ovf;
                bcd_out   = r_ovf ? SAT_BCD : r_acc;
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // The top digit's carry is dropped: it only appears for operands already flagged as overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_load) begin
            r_bin <= bin_in;
            r_acc <= '0;
            r_cnt <= CNT_W'(BIN_W);
            r_ovf <= w_ovf;
        end else if (w_shift) begin
            r_acc <= BCD_W'({w_adj, r_bin[BIN_W-1]});
            r_bin <= {r_bin[BIN_W-2:0], 1'b0};
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq at (8,3), (8,2) and (16,5) with a decimal reference model.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  in_v;
    logic [2:0]  in_rdy;
    logic [2:0]  out_v;
    logic [2:0]  out_r;
    logic [2:0]  ovf;
    logic [15:0] bin_v;
    logic [11:0] bcd_a;
    logic [7:0]  bcd_b;
    logic [19:0] bcd_c;
    logic [19:0] bcd_o [3];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        bcd_o[0] = 20'(bcd_a);
        bcd_o[1] = 20'(bcd_b);
        bcd_o[2] = bcd_c;
    end

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_v[0]), .in_ready(in_rdy[0]),
        .bin_in(bin_v[7:0]), .out_valid(out_v[0]), .out_ready(out_r[0]),
        .bcd_out(bcd_a), .overflow(ovf[0])
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_v[1]), .in_ready(in_rdy[1]),
        .bin_in(bin_v[7:0]), .out_valid(out_v[1]), .out_ready(out_r[1]),
        .bcd_out(bcd_b), .overflow(ovf[1])
    );

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_v[2]), .in_ready(in_rdy[2]),
        .bin_in(bin_v), .out_valid(out_v[2]), .out_ready(out_r[2]),
        .bcd_out(bcd_c), .overflow(ovf[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Called at a negedge with the selected DUT idle; returns at a negedge with it idle again.
    task automatic conv(input int s, input logic [15:0] v, input logic [19:0] exp_bcd,
                        input logic exp_ovf, input int hold, input int lat);
        int          edges;
        logic [19:0] held;
        chk("in_ready_idle", 32'(in_rdy[s]), 1);
        out_r[s] = (hold == 0);
        in_v[s]  = 1'b1;
        bin_v    = v;
        @(posedge clk);
        #1;
        bin_v = ~v;
        edges = 0;
        @(negedge clk);
        chk("in_ready_busy", 32'(in_rdy[s]), 0);
        while (!out_v[s] && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        in_v[s] = 1'b0;
        chk("latency", 32'(edges), 32'(lat));
        chk("bcd", 32'(bcd_o[s]), 32'(exp_bcd));
        chk("ovf", 32'(ovf[s]), 32'(exp_ovf));
        held = bcd_o[s];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_vld", 32'(out_v[s]), 1);
            chk("hold_bcd", 32'(bcd_o[s]), 32'(held));
            chk("hold_rdy", 32'(in_rdy[s]), 0);
        end
        out_r[s] = 1'b1;
        @(negedge clk);
        chk("ret_vld", 32'(out_v[s]), 0);
        chk("ret_bcd", 32'(bcd_o[s]), 0);
        chk("ret_rdy", 32'(in_rdy[s]), 1);
        out_r[s] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        seen;
        int unsigned rv;
        rst_n = 1'b0;
        in_v  = '0;
        out_r = '0;
        bin_v = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_rdy), 32'h7);
        chk("rst_out_valid", 32'(out_v), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_bcd_a", 32'(bcd_a), 0);
        chk("rst_bcd_c", 32'(bcd_c), 0);

        // Released at a negedge and driven at once: the very next edge must accept.
        rst_n = 1'b1;
        conv(0, 16'd255, 20'h255, 1'b0, 0, 8);
        conv(0, 16'd0,   20'h000, 1'b0, 0, 8);
        conv(0, 16'd9,   20'h009, 1'b0, 0, 8);
        conv(0, 16'd10,  20'h010, 1'b0, 0, 8);
        conv(0, 16'd99,  20'h099, 1'b0, 0, 8);
        conv(0, 16'd100, 20'h100, 1'b0, 0, 8);
        conv(0, 16'd77,  20'h077, 1'b0, 5, 8);

        // Reset asserted just after the third shift edge.
        in_v[0]  = 1'b1;
        bin_v    = 16'd200;
        out_r[0] = 1'b1;
        @(posedge clk);
        #1 in_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_vld", 32'(out_v[0]), 0);
        chk("midrst_rdy", 32'(in_rdy[0]), 1);
        chk("midrst_bcd", 32'(bcd_a), 0);
        chk("midrst_ovf", 32'(ovf[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_v[0]) seen = 1'b1;
        end
        chk("no_vld_after_rst", 32'(seen), 0);
        out_r[0] = 1'b0;
        conv(0, 16'd42, 20'h042, 1'b0, 0, 8);

        conv(1, 16'd100, 20'h99, 1'b1, 0, 8);
        conv(1, 16'd99,  20'h99, 1'b0, 0, 8);
        conv(1, 16'd255, 20'h99, 1'b1, 0, 8);
        conv(1, 16'd0,   20'h00, 1'b0, 0, 8);
        conv(1, 16'd57,  20'h57, 1'b0, 0, 8);

        conv(2, 16'd65535, 20'h65535, 1'b0, 0, 16);
        conv(2, 16'd0,     20'h00000, 1'b0, 0, 16);
        conv(2, 16'd10000, 20'h10000, 1'b0, 0, 16);
        for (int i = 0; i < 12; i++) begin
            rv = $urandom_range(0, 65535);
            conv(2, 16'(rv), ref_bcd(rv), 1'b0, 0, 16);
        end
        for (int i = 0; i < 8; i++) begin
            rv = $urandom_range(0, 255);
            conv(0, 16'(rv), ref_bcd(rv), 1'b0, 0, 8);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
